// File: rtl/paillier_result_gather.sv
`timescale 1ns/1ps
// paillier_result_gather
//
// Drains finished Paillier results from the per-core show-ahead result FIFOs
// in strict round-robin block order and serialises them onto a single
// DW-bit valid/ready stream. Each result is N words of K bits, sent as
// N*K/DW beats, least-significant slice of each word first, with m_last on
// the final beat of every result. After `total_results` results the block
// parks in DONE and holds `done` high until the next `start`.
//
// Ports
//   M_AXI_ACLK     : clock
//   M_AXI_ARESETN  : asynchronous active-low reset
//   start          : one-cycle pulse, latches total_results / active_blocks
//   total_results  : number of results to gather
//   active_blocks  : cores in use (0 or >BLOCK_COUNT means all)
//   rd_rdy         : per-FIFO pop strobe (at most one bit high)
//   rd_dout        : flattened FIFO heads, block o at [o*K +: K]
//   rd_cnt         : flattened FIFO occupancies, block o at [o*CW +: CW]
//   m_data/m_valid/m_ready/m_last : output stream
//   m_block        : source block of the current beat
//   busy           : results still outstanding
//   done           : all results sent (level, cleared by start)
module paillier_result_gather #(
  parameter int BLOCK_COUNT = 25,
  parameter int K           = 128,
  parameter int N           = 32,
  parameter int DW          = 64,
  parameter int CW          = $clog2(N) + 1,
  parameter int BW          = $clog2(BLOCK_COUNT + 1)
) (
  input  logic                     M_AXI_ACLK,
  input  logic                     M_AXI_ARESETN,
  input  logic                     start,
  input  logic [63:0]              total_results,
  input  logic [BW-1:0]            active_blocks,
  output logic [BLOCK_COUNT-1:0]   rd_rdy,
  input  logic [BLOCK_COUNT*K-1:0] rd_dout,
  input  logic [BLOCK_COUNT*CW-1:0] rd_cnt,
  output logic [DW-1:0]            m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [BW-1:0]            m_block,
  output logic                     busy,
  output logic                     done
);

  localparam int BEATS = K / DW;
  localparam int BTW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WCW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [BTW-1:0] LAST_BEAT  = BTW'(BEATS - 1);
  localparam logic [WCW-1:0] LAST_WORD  = WCW'(N - 1);
  localparam logic [BW-1:0]  MAX_BLOCKS = BW'(BLOCK_COUNT);
  localparam logic [CW-1:0]  FULL_CNT   = CW'(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [63:0]    total_q;
  logic [63:0]    result_cnt_q;
  logic [BW-1:0]  active_q;
  logic [BW-1:0]  blk_q;
  logic [WCW-1:0] word_q;
  logic [BTW-1:0] beat_q;
  logic [K-1:0]   hold_q;

  logic           start_ok;
  logic           fire;
  logic           last_beat;
  logic           last_word;
  logic           all_sent;
  logic           head_full;
  logic           pop;
  logic [BW-1:0]  active_eff;
  logic [BW-1:0]  blk_inc;
  logic [BW-1:0]  blk_next;
  logic [CW-1:0]  head_cnt;
  logic [K-1:0]   head_word;

  // Out-of-range active counts fall back to the full array.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    active_eff = active_blocks;
    if (active_blocks == '0 || active_blocks > MAX_BLOCKS) begin
      active_eff = MAX_BLOCKS;
    end
  end

  assign head_cnt  = rd_cnt[int'(blk_q) * CW +: CW];
  assign head_word = rd_dout[int'(blk_q) * K +: K];
  assign head_full = (head_cnt >= FULL_CNT);

  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign fire      = (state_q == S_SEND) && m_ready;
  assign last_beat = (beat_q == LAST_BEAT);
  assign last_word = (word_q == LAST_WORD);
  assign all_sent  = (result_cnt_q == total_q);

  assign blk_inc   = blk_q + BW'(1);
  assign blk_next  = (blk_inc == active_q) ? '0 : blk_inc;

  // Next-state logic. A pop is only ever issued on the current block, either
  // when WAIT has confirmed a whole result is present, or on the handshake of
  // the last beat of a non-final word (refilling the holding register with
  // no bubble).
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (all_sent) begin
          state_d = S_DONE;
        end else if (head_full) begin
          pop     = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (fire && last_beat) begin
          if (!last_word) pop = 1'b1;
          else            state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q      <= S_IDLE;
      total_q      <= '0;
      result_cnt_q <= '0;
      active_q     <= '0;
      blk_q        <= '0;
      word_q       <= '0;
      beat_q       <= '0;
      // NOTE: the holding register is a single word of flops, not a memory,
      // so it is reset like the rest to give a defined m_data source.
      hold_q       <= '0;
    end else begin
      state_q <= state_d;

      if (start_ok) begin
        total_q      <= total_results;
        active_q     <= active_eff;
        result_cnt_q <= '0;
        blk_q        <= '0;
        word_q       <= '0;
        beat_q       <= '0;
      end

      if (pop) hold_q <= head_word;

      if (state_q == S_WAIT && pop) begin
        word_q <= '0;
        beat_q <= '0;
      end

      if (fire) begin
        if (!last_beat) begin
          beat_q <= beat_q + BTW'(1);
        end else if (!last_word) begin
          word_q <= word_q + WCW'(1);
          beat_q <= '0;
        end else begin
          result_cnt_q <= result_cnt_q + 64'd1;
          blk_q        <= blk_next;
        end
      end
    end
  end

  // Outputs are decoded from registered state, so they hold steady while a
  // beat is stalled by m_ready.
  assign rd_rdy  = pop ? (BLOCK_COUNT'(1) << blk_q) : '0;
  assign m_valid = (state_q == S_SEND);
  assign m_data  = (state_q == S_SEND) ? hold_q[int'(beat_q) * DW +: DW] : '0;
  assign m_last  = (state_q == S_SEND) && last_beat && last_word;
  assign m_block = blk_q;
  // WAIT with nothing left to send is the one-cycle hop into DONE.
  assign busy    = (state_q == S_SEND) || (state_q == S_WAIT && !all_sent);
  assign done    = (state_q == S_DONE);

endmodule
